// File: rtl/ptr_chase_engine_pkg.sv
// Shared definitions for the pointer-chase engine: FSM encoding, pointer
// stride and the default parameter values used by the top level.
package ptr_chase_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Seed table entries are 64-bit pointers.
  localparam int PTR_STRIDE = 8;
  localparam int PTR_SHIFT  = 3;

  localparam int DEF_MAX_THREADS  = 256;
  localparam int DEF_FIFO_DEPTH   = 32;
  localparam int DEF_AFULL_MARGIN = 4;
  localparam int DEF_ADDR_W       = 48;
  localparam int DEF_TAG_W        = 32;

endpackage

// File: rtl/ptr_chase_engine_fifo.sv
// Reissue queue: first-word-fall-through FIFO holding {tag, next address}
// pairs waiting to be sent back to the memory controller.
module ptr_chase_engine_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 80
) (
  input  logic                     clk,
  input  logic                     r_reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_fire = rd_en && !empty;
  // A pop in the same cycle frees the slot a full queue would otherwise refuse.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ptr_chase_engine.sv
// Pointer-chase engine: seeds N threads from a pointer table, then reissues a
// load for every returned pointer until the shared hop budget is spent.
module ptr_chase_engine
  import ptr_chase_engine_pkg::*;
#(
  parameter int MAX_THREADS  = DEF_MAX_THREADS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int TAG_W        = DEF_TAG_W
) (
  input  logic                         clk,
  input  logic                         r_reset,
  input  logic                         start,
  output logic                         idle,
  output logic                         done,
  input  logic [ADDR_W-1:0]            base_address,
  input  logic [$clog2(MAX_THREADS):0] num_threads,
  input  logic [31:0]                  hop_budget,
  input  logic                         null_stop_en,
  output logic                         mc_req_ld,
  output logic [ADDR_W-1:0]            mc_req_vadr,
  output logic [TAG_W-1:0]             mc_req_rdctl,
  input  logic                         mc_rd_rq_stall,
  input  logic                         mc_rsp_push,
  input  logic [TAG_W-1:0]             mc_rsp_rdctl,
  input  logic [63:0]                  mc_rsp_data,
  output logic                         mc_rsp_stall,
  output logic [31:0]                  hops_done
);

  localparam int NT_W  = $clog2(MAX_THREADS) + 1;
  localparam int OUT_W = NT_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int Q_W   = ADDR_W + TAG_W;
  localparam logic [CNT_W-1:0] AFULL_LEVEL = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);

  // Limit the requested seed count to the number of supported threads.
  function automatic logic [NT_W-1:0] clamp_threads(input logic [NT_W-1:0] n);
    return (n > NT_W'(MAX_THREADS)) ? NT_W'(MAX_THREADS) : n;
  endfunction

  // Budget decrement that sticks at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] b);
    return (b == 32'd0) ? 32'd0 : b - 32'd1;
  endfunction

  state_e            state;
  logic [ADDR_W-1:0] base_q;
  logic [NT_W-1:0]   nthr_q;
  logic              null_en_q;
  logic [31:0]       budget_q;
  logic [NT_W-1:0]   seed_idx;
  logic [OUT_W-1:0]  outstanding;

  logic              stall_p1;
  logic              rsp_vld_p1;
  logic [TAG_W-1:0]  rsp_tag_p1;
  logic [ADDR_W-1:0] rsp_data_p1;

  logic [Q_W-1:0]    fifo_wr_data;
  logic [Q_W-1:0]    fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic              cap;
  logic [NT_W-1:0]   nthr_clamped;
  logic              rsp_null;
  logic              push_ok;
  logic              pop;
  logic              seed_fire;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [TAG_W-1:0]  issue_tag;
  logic              run_drained;
  logic              rsp_data_unused;

  // Only the low ADDR_W bits of a returned pointer are meaningful.
  assign rsp_data_unused = ^{mc_rsp_data[63:ADDR_W], fifo_full};

  assign cap          = (state == ST_IDLE) && start;
  assign nthr_clamped = clamp_threads(num_threads);
  assign rsp_null     = null_en_q && (rsp_data_p1 == '0);
  assign push_ok      = rsp_vld_p1 && (state != ST_IDLE) && (budget_q != 32'd0) && !rsp_null;
  assign pop          = (state == ST_RUN) && !fifo_empty && !stall_p1;
  assign seed_fire    = (state == ST_SEED) && !stall_p1;
  assign issue        = pop || seed_fire;
  assign issue_addr   = pop ? fifo_rd_data[ADDR_W-1:0]
                            : base_q + (ADDR_W'(seed_idx) << PTR_SHIFT);
  assign issue_tag    = pop ? fifo_rd_data[Q_W-1:ADDR_W] : TAG_W'(seed_idx);
  assign fifo_wr_data = {rsp_tag_p1, rsp_data_p1};
  assign run_drained  = (state == ST_RUN) && (outstanding == '0) && fifo_empty && !rsp_vld_p1;

  assign idle         = (state == ST_IDLE) && !start;
  assign mc_rsp_stall = (state == ST_SEED) || (fifo_count >= AFULL_LEVEL);

  ptr_chase_engine_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (Q_W)
  ) u_fifo (
    .clk     (clk),
    .r_reset (r_reset),
    .wr_en   (push_ok),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Stage p1: register MC backpressure and the response valid; stray
  // responses while idle are dropped here.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      stall_p1   <= 1'b0;
      rsp_vld_p1 <= 1'b0;
    end else begin
      stall_p1   <= mc_rd_rq_stall;
      rsp_vld_p1 <= mc_rsp_push && (state != ST_IDLE);
    end
  end

  // Stage p1: response payload, carried without reset.
  always_ff @(posedge clk) begin
    rsp_tag_p1  <= mc_rsp_rdctl;
    rsp_data_p1 <= mc_rsp_data[ADDR_W-1:0];
  end

  // Run configuration latched on launch.
  always_ff @(posedge clk) begin
    if (cap) begin
      base_q    <= base_address;
      nthr_q    <= nthr_clamped;
      null_en_q <= null_stop_en;
    end
  end

  // Run counters: loads in flight, responses seen and remaining hop budget.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      outstanding <= '0;
      hops_done   <= '0;
      budget_q    <= '0;
    end else if (cap) begin
      outstanding <= '0;
      hops_done   <= '0;
      budget_q    <= hop_budget;
    end else begin
      if (issue && !rsp_vld_p1) begin
        outstanding <= outstanding + 1'b1;
      end else if (!issue && rsp_vld_p1) begin
        outstanding <= outstanding - 1'b1;
      end
      if (rsp_vld_p1) begin
        hops_done <= hops_done + 32'd1;
      end
      if (push_ok) begin
        budget_q <= sat_dec(budget_q);
      end
    end
  end

  // Control FSM with registered request and completion outputs.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state        <= ST_IDLE;
      seed_idx     <= '0;
      mc_req_ld    <= 1'b0;
      mc_req_vadr  <= '0;
      mc_req_rdctl <= '0;
      done         <= 1'b0;
    end else begin
      mc_req_ld <= issue;
      done      <= 1'b0;
      if (issue) begin
        mc_req_vadr  <= issue_addr;
        mc_req_rdctl <= issue_tag;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            seed_idx <= '0;
            state    <= (nthr_clamped == '0) ? ST_RUN : ST_SEED;
          end
        end
        ST_SEED: begin
          if (seed_fire) begin
            seed_idx <= seed_idx + 1'b1;
            if (seed_idx == nthr_q - NT_W'(1)) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (run_drained) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptr_chase_engine.sv
// Directed bench for ptr_chase_engine with a simple echoing memory model.
module tb_ptr_chase_engine;

  logic        clk = 1'b0;
  logic        r_reset = 1'b1;
  logic        start = 1'b0;
  logic        idle;
  logic        done;
  logic [47:0] base_address = '0;
  logic [8:0]  num_threads = '0;
  logic [31:0] hop_budget = '0;
  logic        null_stop_en = 1'b0;
  logic        mc_req_ld;
  logic [47:0] mc_req_vadr;
  logic [31:0] mc_req_rdctl;
  logic        mc_rd_rq_stall = 1'b0;
  logic        mc_rsp_push = 1'b0;
  logic [31:0] mc_rsp_rdctl = '0;
  logic [63:0] mc_rsp_data = '0;
  logic        mc_rsp_stall;
  logic [31:0] hops_done;

  typedef struct {
    logic [47:0] addr;
    logic [31:0] tag;
    int          cyc;
  } req_t;

  req_t log_q[$];
  req_t pend_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   rsp_cnt = 0;
  int   fifo_est = 0;
  bit   hold = 1'b0;
  bit   null_mode = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  ptr_chase_engine dut (
    .clk            (clk),
    .r_reset        (r_reset),
    .start          (start),
    .idle           (idle),
    .done           (done),
    .base_address   (base_address),
    .num_threads    (num_threads),
    .hop_budget     (hop_budget),
    .null_stop_en   (null_stop_en),
    .mc_req_ld      (mc_req_ld),
    .mc_req_vadr    (mc_req_vadr),
    .mc_req_rdctl   (mc_req_rdctl),
    .mc_rd_rq_stall (mc_rd_rq_stall),
    .mc_rsp_push    (mc_rsp_push),
    .mc_rsp_rdctl   (mc_rsp_rdctl),
    .mc_rsp_data    (mc_rsp_data),
    .mc_rsp_stall   (mc_rsp_stall),
    .hops_done      (hops_done)
  );

  always #5 clk = ~clk;

  // Memory model: log every load, answer in order with data = addr + 0x40
  // (or 0 for tag 2 in null mode), one response per cycle, >= 2 cycles later.
  always @(negedge clk) begin
    req_t r;
    cyc = cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (mc_req_ld) begin
      r.addr = mc_req_vadr;
      r.tag  = mc_req_rdctl;
      r.cyc  = cyc;
      log_q.push_back(r);
      pend_q.push_back(r);
    end
    mc_rsp_push = 1'b0;
    if (!hold && pend_q.size() > 0 && (cyc - pend_q[0].cyc) >= 2) begin
      r = pend_q.pop_front();
      mc_rsp_push  = 1'b1;
      mc_rsp_rdctl = r.tag;
      mc_rsp_data  = (null_mode && r.tag == 32'd2) ? 64'd0 : ({16'h0, r.addr} + 64'h40);
    end
  end

  // Responses delivered, and responses that have had time to land in the queue.
  always @(posedge clk) begin
    fifo_est <= rsp_cnt;
    if (mc_rsp_push) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic do_start(input logic [47:0] b, input int n, input logic [31:0] bud, input logic ne);
    @(negedge clk);
    base_address = b;
    num_threads  = 9'(n);
    hop_budget   = bud;
    null_stop_en = ne;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (mc_req_ld !== 1'b0) begin $display("FAIL reset_req_ld got=%b exp=0", mc_req_ld); n_fail++; end
    n_chk++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); n_fail++; end
    n_chk++; if (mc_rsp_stall !== 1'b0) begin $display("FAIL reset_rsp_stall got=%b exp=0", mc_rsp_stall); n_fail++; end
    n_chk++; if (hops_done !== 32'd0) begin $display("FAIL reset_hops got=%0d exp=0", hops_done); n_fail++; end
    n_chk++; if (mc_req_vadr !== 48'd0) begin $display("FAIL reset_vadr got=%h exp=0", mc_req_vadr); n_fail++; end
    n_chk++; if (mc_req_rdctl !== 32'd0) begin $display("FAIL reset_rdctl got=%h exp=0", mc_req_rdctl); n_fail++; end
    n_chk++; if (idle !== 1'b1) begin $display("FAIL reset_idle got=%b exp=1", idle); n_fail++; end
    r_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b0, d0, n;
    bit ok;
    int hop[2];
    logic [47:0] exp_a;
    logic [31:0] t;
    b0 = log_q.size(); d0 = done_cnt; hold = 1'b0; null_mode = 1'b0;
    hop[0] = 0; hop[1] = 0;
    do_start(48'h1000, 2, 32'd4, 1'b0);
    wait_done(200, ok);
    n_chk++; if (!ok) begin $display("FAIL basic_done_timeout got=none exp=done"); n_fail++; end
    repeat (3) @(negedge clk);
    n = log_q.size() - b0;
    n_chk++; if (n != 6) begin $display("FAIL basic_load_count got=%0d exp=6", n); n_fail++; end
    if (n >= 2) begin
      n_chk++;
      if (log_q[b0].addr !== 48'h1000 || log_q[b0].tag !== 32'd0 ||
          log_q[b0+1].addr !== 48'h1008 || log_q[b0+1].tag !== 32'd1) begin
        $display("FAIL basic_seed got=%h/%0d %h/%0d exp=1000/0 1008/1",
                 log_q[b0].addr, log_q[b0].tag, log_q[b0+1].addr, log_q[b0+1].tag);
        n_fail++;
      end
    end
    for (int i = b0; i < log_q.size(); i++) begin
      t = log_q[i].tag;
      n_chk++;
      if (t > 32'd1) begin
        $display("FAIL basic_tag got=%0d exp=<2", t); n_fail++;
      end else begin
        exp_a = 48'h1000 + 48'(8 * t) + 48'(64 * hop[t]);
        hop[t]++;
        if (log_q[i].addr !== exp_a) begin
          $display("FAIL basic_chase_addr got=%h exp=%h", log_q[i].addr, exp_a); n_fail++;
        end
      end
    end
    n_chk++; if (hops_done !== 32'd6) begin $display("FAIL basic_hops got=%0d exp=6", hops_done); n_fail++; end
    n_chk++; if (done_cnt - d0 != 1) begin $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); n_fail++; end
    n_chk++; if (idle !== 1'b1) begin $display("FAIL basic_idle got=%b exp=1", idle); n_fail++; end
  endtask

  task automatic test_zero_threads();
    int b0;
    b0 = log_q.size();
    do_start(48'h5000, 0, 32'd10, 1'b0);
    n_chk++; if (done !== 1'b0 || idle !== 1'b0) begin $display("FAIL zero_cycle1 got=done%b idle%b exp=done0 idle0", done, idle); n_fail++; end
    @(negedge clk);
    n_chk++; if (done !== 1'b1) begin $display("FAIL zero_done got=%b exp=1", done); n_fail++; end
    n_chk++; if (idle !== 1'b1) begin $display("FAIL zero_idle got=%b exp=1", idle); n_fail++; end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin $display("FAIL zero_done_pulse got=%b exp=0", done); n_fail++; end
    repeat (3) @(negedge clk);
    n_chk++; if (log_q.size() != b0) begin $display("FAIL zero_no_loads got=%0d exp=0", log_q.size() - b0); n_fail++; end
    n_chk++; if (hops_done !== 32'd0) begin $display("FAIL zero_hops got=%0d exp=0", hops_done); n_fail++; end
  endtask

  task automatic test_null_stop();
    int b0, d0, n, tag2;
    bit ok;
    int hop[4];
    logic [47:0] exp_a;
    logic [31:0] t;
    b0 = log_q.size(); d0 = done_cnt; hold = 1'b0; null_mode = 1'b1;
    for (int i = 0; i < 4; i++) hop[i] = 0;
    tag2 = 0;
    do_start(48'h2000, 4, 32'd20, 1'b1);
    wait_done(400, ok);
    n_chk++; if (!ok) begin $display("FAIL null_done_timeout got=none exp=done"); n_fail++; end
    repeat (3) @(negedge clk);
    null_mode = 1'b0;
    n = log_q.size() - b0;
    n_chk++; if (n != 24) begin $display("FAIL null_load_count got=%0d exp=24", n); n_fail++; end
    for (int i = b0; i < log_q.size(); i++) begin
      t = log_q[i].tag;
      if (t == 32'd2) tag2++;
      n_chk++;
      if (t > 32'd3) begin
        $display("FAIL null_tag got=%0d exp=<4", t); n_fail++;
      end else begin
        exp_a = 48'h2000 + 48'(8 * t) + 48'(64 * hop[t]);
        hop[t]++;
        if (log_q[i].addr !== exp_a) begin
          $display("FAIL null_chase_addr got=%h exp=%h", log_q[i].addr, exp_a); n_fail++;
        end
      end
    end
    n_chk++; if (tag2 != 1) begin $display("FAIL null_tag2_loads got=%0d exp=1", tag2); n_fail++; end
    n_chk++; if (hops_done !== 32'd24) begin $display("FAIL null_hops got=%0d exp=24", hops_done); n_fail++; end
    n_chk++; if (done_cnt - d0 != 1) begin $display("FAIL null_done_count got=%0d exp=1", done_cnt - d0); n_fail++; end
  endtask

  task automatic test_flood();
    int b0, base_rsp, est;
    bit ok;
    logic exp_st;
    b0 = log_q.size(); hold = 1'b1; null_mode = 1'b0;
    do_start(48'h8000, 30, 32'd40, 1'b0);
    for (int i = 0; i < 100 && (log_q.size() - b0) < 30; i++) @(negedge clk);
    n_chk++; if (log_q.size() - b0 != 30) begin $display("FAIL flood_seed_count got=%0d exp=30", log_q.size() - b0); n_fail++; end
    mc_rd_rq_stall = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (mc_rsp_stall !== 1'b0) begin $display("FAIL flood_stall_empty got=%b exp=0", mc_rsp_stall); n_fail++; end
    base_rsp = rsp_cnt;
    hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      est = fifo_est - base_rsp;
      exp_st = (est >= 28);
      n_chk++;
      if (mc_rsp_stall !== exp_st) begin
        $display("FAIL flood_rsp_stall queued=%0d got=%b exp=%b", est, mc_rsp_stall, exp_st); n_fail++;
      end
    end
    repeat (7) @(negedge clk);
    n_chk++; if (log_q.size() - b0 != 30) begin $display("FAIL flood_no_issue got=%0d exp=30", log_q.size() - b0); n_fail++; end
    n_chk++; if (hops_done !== 32'd30) begin $display("FAIL flood_hops_mid got=%0d exp=30", hops_done); n_fail++; end
    mc_rd_rq_stall = 1'b0;
    wait_done(600, ok);
    n_chk++; if (!ok) begin $display("FAIL flood_done_timeout got=none exp=done"); n_fail++; end
    repeat (3) @(negedge clk);
    n_chk++; if (hops_done !== 32'd70) begin $display("FAIL flood_hops got=%0d exp=70", hops_done); n_fail++; end
    n_chk++; if (log_q.size() - b0 != 70) begin $display("FAIL flood_load_count got=%0d exp=70", log_q.size() - b0); n_fail++; end
    n_chk++; if (mc_rsp_stall !== 1'b0) begin $display("FAIL flood_stall_end got=%b exp=0", mc_rsp_stall); n_fail++; end
  endtask

  task automatic test_reset_mid_run();
    int b0, b1, d0;
    bit ok;
    b0 = log_q.size(); hold = 1'b1; null_mode = 1'b0;
    do_start(48'h3000, 8, 32'd100, 1'b0);
    for (int i = 0; i < 50 && (log_q.size() - b0) < 8; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_chk++; if (mc_req_vadr !== 48'h3038) begin $display("FAIL rstmid_last_seed got=%h exp=3038", mc_req_vadr); n_fail++; end
    r_reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mc_req_ld !== 1'b0 || done !== 1'b0 || mc_rsp_stall !== 1'b0 || hops_done !== 32'd0 ||
        mc_req_vadr !== 48'd0 || mc_req_rdctl !== 32'd0) begin
      $display("FAIL rstmid_outputs got=ld%b done%b stall%b hops%0d vadr%h tag%h exp=all0",
               mc_req_ld, done, mc_rsp_stall, hops_done, mc_req_vadr, mc_req_rdctl);
      n_fail++;
    end
    r_reset = 1'b0;
    b1 = log_q.size(); d0 = done_cnt;
    hold = 1'b0;
    repeat (15) @(negedge clk);
    n_chk++; if (hops_done !== 32'd0) begin $display("FAIL rstmid_stray_hops got=%0d exp=0", hops_done); n_fail++; end
    n_chk++; if (log_q.size() != b1) begin $display("FAIL rstmid_stray_loads got=%0d exp=0", log_q.size() - b1); n_fail++; end
    n_chk++; if (idle !== 1'b1 || done_cnt != d0) begin $display("FAIL rstmid_idle got=idle%b dones%0d exp=idle1 dones0", idle, done_cnt - d0); n_fail++; end
    do_start(48'h4000, 1, 32'd2, 1'b0);
    wait_done(100, ok);
    n_chk++; if (!ok) begin $display("FAIL rstmid_rerun_timeout got=none exp=done"); n_fail++; end
    repeat (3) @(negedge clk);
    n_chk++; if (hops_done !== 32'd3) begin $display("FAIL rstmid_rerun_hops got=%0d exp=3", hops_done); n_fail++; end
    n_chk++;
    if (log_q.size() - b1 != 3) begin
      $display("FAIL rstmid_rerun_loads got=%0d exp=3", log_q.size() - b1); n_fail++;
    end else if (log_q[b1].addr !== 48'h4000 || log_q[b1+1].addr !== 48'h4040 || log_q[b1+2].addr !== 48'h4080) begin
      $display("FAIL rstmid_rerun_addr got=%h %h %h exp=4000 4040 4080",
               log_q[b1].addr, log_q[b1+1].addr, log_q[b1+2].addr);
      n_fail++;
    end
  endtask

  task automatic test_clamp();
    int b0, n, bad;
    bit ok;
    b0 = log_q.size(); hold = 1'b0; null_mode = 1'b0; bad = 0;
    do_start(48'h0, 256 + 5, 32'd0, 1'b0);
    wait_done(1000, ok);
    n_chk++; if (!ok) begin $display("FAIL clamp_done_timeout got=none exp=done"); n_fail++; end
    repeat (3) @(negedge clk);
    n = log_q.size() - b0;
    n_chk++; if (n != 256) begin $display("FAIL clamp_seed_count got=%0d exp=256", n); n_fail++; end
    for (int i = 0; i < n && i < 256; i++) begin
      if (log_q[b0+i].tag !== 32'(i) || log_q[b0+i].addr !== 48'(8 * i)) bad++;
    end
    n_chk++; if (bad != 0) begin $display("FAIL clamp_seed_order got=%0d_bad exp=0_bad", bad); n_fail++; end
    n_chk++; if (hops_done !== 32'd256) begin $display("FAIL clamp_hops got=%0d exp=256", hops_done); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_threads();
    test_null_stop();
    test_flood();
    test_reset_mid_run();
    test_clamp();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
